// File: rtl/float_type_pkg.sv
// Shared float datapath types: operand classes, divider states and IEEE-754 constants.
package float_type;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } type_of_float;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIVIDE,
        ROUND,
        DONE
    } fp_div_state_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam int          FP_BIAS    = 127;
    localparam logic [7:0]  FP_INF_EXP = 8'hFF;

endpackage

// File: rtl/div_round_rne.sv
// Normalises the raw quotient, rounds to nearest-even and applies the exponent range limits.
module div_round_rne #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [MAN_W+2:0]        q,
    input  logic                    sticky,
    input  logic signed [EXP_W+1:0] e,
    input  logic                    sign,
    output logic [EXP_W+MAN_W:0]    result,
    output logic                    U,
    output logic                    O
);

    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);
    localparam logic signed [EW-1:0] EMIN = EW'(0);

    logic [MAN_W+1:0]        qn;
    logic signed [EW-1:0]    en;
    logic [MAN_W-1:0]        man;
    logic [MAN_W-1:0]        man_r;
    logic                    carry;
    logic                    guard;
    logic                    rest;
    logic                    inc;

    always_comb begin
        qn     = q[MAN_W+2] ? q[MAN_W+1:0] : {q[MAN_W:0], 1'b0};
        en     = q[MAN_W+2] ? e : e - ONE;
        man    = qn[MAN_W+1:2];
        guard  = qn[1];
        rest   = qn[0] | sticky;
        inc    = guard & (rest | man[0]);
        {carry, man_r} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        // A rounding carry leaves man_r at zero, i.e. exactly 1.0 at the next exponent.
        if (carry)
            en = en + ONE;
        U      = 1'b0;
        O      = 1'b0;
        result = {sign, en[EXP_W-1:0], man_r};
        if (en >= EMAX) begin
            result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            O      = 1'b1;
        end else if (en <= EMIN) begin
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
            U      = 1'b1;
        end
    end

endmodule

// File: rtl/if_normal.sv
// Classifies one IEEE-754 operand; denormals are reported as ZERO so they flush.
module if_normal
    import float_type::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] f,
    output logic [1:0]           f_type
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f = f[EXP_W+MAN_W-1:MAN_W];
    assign man_f = f[MAN_W-1:0];

    always_comb begin
        f_type = ZERO;
        if (exp_f == '0)
            f_type = ZERO;
        else if (exp_f == '1)
            f_type = (man_f == '0) ? INF : NAN;
        else
            f_type = NORMAL;
    end

endmodule

// File: rtl/fp32_divider.sv
// Sequential IEEE-754 divider: special-case check, radix-2 restoring divide, RNE round.
module fp32_divider
    import float_type::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] fp_result,
    output logic                 U,
    output logic                 O,
    output logic                 N,
    output logic                 Z
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int EW    = EXP_W + 2;
    localparam int STEPS = MAN_W + 3;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic signed [EW-1:0] BIAS_E = EW'(2**(EXP_W-1) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    fp_div_state_t           state;
    logic [W-1:0]            a_r;
    logic [W-1:0]            b_r;
    logic signed [EW-1:0]    e_r;
    logic [MAN_W+1:0]        rem;
    logic [MAN_W:0]          dvs;
    logic [MAN_W+2:0]        q;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              ta_raw;
    logic [1:0]              tb_raw;
    type_of_float            ta;
    type_of_float            tb;
    logic                    sign;
    logic signed [EW-1:0]    e_calc;
    logic                    q_bit;
    logic [MAN_W+1:0]        rem_sub;
    logic [W-1:0]            rnd_result;
    logic                    rnd_u;
    logic                    rnd_o;

    if_normal #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (.f(a_r), .f_type(ta_raw));
    if_normal #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (.f(b_r), .f_type(tb_raw));

    assign ta     = type_of_float'(ta_raw);
    assign tb     = type_of_float'(tb_raw);
    assign sign   = a_r[W-1] ^ b_r[W-1];
    assign e_calc = $signed({2'b00, a_r[W-2:MAN_W]}) - $signed({2'b00, b_r[W-2:MAN_W]}) + BIAS_E;

    always_comb begin
        q_bit   = (rem >= {1'b0, dvs});
        rem_sub = q_bit ? rem - {1'b0, dvs} : rem;
    end

    div_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .q      (q),
        .sticky (|rem),
        .e      (e_r),
        .sign   (sign),
        .result (rnd_result),
        .U      (rnd_u),
        .O      (rnd_o)
    );

    // Special operands resolve in CHECK and jump straight to DONE; the rest iterate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            fp_result <= '0;
            {U, O, N, Z} <= 4'b0000;
            a_r       <= '0;
            b_r       <= '0;
            e_r       <= '0;
            rem       <= '0;
            dvs       <= '0;
            q         <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        in_ready <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    {U, O, N, Z} <= 4'b0000;
                    if (ta == NAN || tb == NAN || (ta == ZERO && tb == ZERO) ||
                        (ta == INF && tb == INF)) begin
                        fp_result <= QNAN;
                        N         <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (tb == ZERO || ta == INF) begin
                        fp_result <= {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        Z         <= (tb == ZERO) && (ta == NORMAL);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (ta == ZERO || tb == INF) begin
                        fp_result <= {sign, {(W-1){1'b0}}};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        e_r   <= e_calc;
                        rem   <= {2'b01, a_r[MAN_W-1:0]};
                        dvs   <= {1'b1, b_r[MAN_W-1:0]};
                        q     <= '0;
                        cnt   <= '0;
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem <= rem_sub << 1;
                    q   <= {q[MAN_W+1:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(STEPS - 1))
                        state <= ROUND;
                end
                ROUND: begin
                    fp_result    <= rnd_result;
                    {U, O, N, Z} <= {rnd_u, rnd_o, 2'b00};
                    out_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Protocol and encoding sanity properties.
    assert property (@(posedge clk) disable iff (rst) in_valid |-> !$isunknown({a, b}));
    assert property (@(posedge clk) disable iff (rst)
                     (out_valid && !out_ready) |=> $stable(fp_result));
    assert property (@(posedge clk)
                     state inside {IDLE, CHECK, DIVIDE, ROUND, DONE});

endmodule

// File: tb/tb_fp32_divider.sv
// Directed-vector bench for fp32_divider with hand-computed quotients, flags and latency.
module tb_fp32_divider;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_result;
    logic        U;
    logic        O;
    logic        N;
    logic        Z;

    int n_checks = 0;
    int n_fail   = 0;

    fp32_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_result (fp_result),
        .U         (U),
        .O         (O),
        .N         (N),
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept is the first counted edge; lat is the edge count at which out_valid is seen.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check_output("in_ready_before_op", {31'b0, in_ready}, 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_output("out_valid_seen", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic apply_stimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                  input logic [31:0] exp_res, input logic [3:0] exp_flags,
                                  input int exp_lat);
        int lat;
        run_op(av, bv, lat);
        check_output({tag, "_result"}, fp_result, exp_res);
        check_output({tag, "_flags_UONZ"}, {28'b0, U, O, N, Z}, {28'b0, exp_flags});
        check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        bit stale;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'h0;
        b         = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_in_ready",  {31'b0, in_ready},  32'd1);
        check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("reset_result",    fp_result,          32'h0);
        check_output("reset_flags",     {28'b0, U, O, N, Z}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] normal quotients");
        apply_stimulus("six_div_two",  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29);
        apply_stimulus("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29);
        apply_stimulus("one_div_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 29);

        $display("[TB] special operands");
        apply_stimulus("pos_div_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 2);
        apply_stimulus("neg_div_zero",  32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001, 2);
        apply_stimulus("zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0010, 2);
        apply_stimulus("inf_div_inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0010, 2);
        apply_stimulus("inf_div_two",   32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 2);
        apply_stimulus("zero_div_two",  32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 2);

        $display("[TB] range limits");
        apply_stimulus("overflow",      32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0100, 29);
        apply_stimulus("underflow_pos", 32'h00800000, 32'h40000000, 32'h00000000, 4'b1000, 29);
        apply_stimulus("underflow_neg", 32'h80800000, 32'h40000000, 32'h80000000, 4'b1000, 29);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        run_op(32'h40C00000, 32'h40000000, lat);
        for (int i = 0; i < 10; i++) begin
            check_output("bp_result",    fp_result,           32'h40400000);
            check_output("bp_flags",     {28'b0, U, O, N, Z}, 32'h0);
            check_output("bp_in_ready",  {31'b0, in_ready},   32'd0);
            check_output("bp_out_valid", {31'b0, out_valid},  32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("release_in_ready",  {31'b0, in_ready},  32'd1);
        check_output("release_out_valid", {31'b0, out_valid}, 32'd0);
        apply_stimulus("back_to_back", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29);

        $display("[TB] reset mid-divide");
        a        = 32'h40C00000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("abort_in_ready",  {31'b0, in_ready},  32'd1);
        check_output("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("abort_result",    fp_result,          32'h0);
        check_output("abort_flags",     {28'b0, U, O, N, Z}, 32'h0);
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check_output("abort_no_stale", {31'b0, stale}, 32'd0);
        apply_stimulus("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_divider.md
Name: fp32_divider

Overview:
- Sequential IEEE-754 single-precision divider: fp_result = a / b, using a radix-2 restoring mantissa divider.
- Companion to the combinational product multiplier in the float datapath, with the same flag outputs U/O/N plus Z (divide-by-zero).
- Valid/ready handshake on both sides, one operation in flight. Round-to-nearest-even; denormal operands and results are flushed to zero.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. Bias = 2^(EXP_W-1)-1. Test values below use the defaults.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  divider can accept operands.
- a  in  32  dividend, IEEE-754 single.
- b  in  32  divisor, IEEE-754 single.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- fp_result  out  32  quotient.
- U  out  1  underflow (result flushed to zero).
- O  out  1  overflow (result forced to infinity).
- N  out  1  invalid; result is NaN.
- Z  out  1  finite nonzero / zero.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, fp_result=0, U=O=N=Z=0. rst in any state aborts the operation; the next edge enters IDLE; a held result is discarded.
- State machine: IDLE -> CHECK -> DIVIDE -> ROUND -> DONE -> IDLE. CHECK goes straight to DONE for special cases.
- in_ready=1 only in IDLE. On accept (in_valid && in_ready), a and b are registered; later input changes are ignored.
- CHECK classifies each operand with if_normal (ZERO/denormal treated as zero). Sign = a[31]^b[31]. Precedence:
  - either NaN, 0/0, or inf/inf -> 32'h7FC00000, N=1.
  - finite nonzero / 0 -> signed infinity, Z=1.
  - inf / finite -> signed infinity.
  - 0 / nonzero, or finite / inf -> signed zero.
- Otherwise, in CHECK: exponent e = ea - eb + 127, held as a 10-bit signed value; remainder = {1,ma}; divisor = {1,mb}.
- DIVIDE runs MAN_W+3 = 26 cycles, one quotient bit per cycle, MSB first:
  - if remainder >= divisor: q bit = 1 and remainder -= divisor; else q bit = 0.
  - remainder <<= 1 after each step.
  - sticky = |remainder after the last step.
- ROUND (one cycle, in div_round_rne):
  - if q[25]==0, shift q left by 1 and decrement e.
  - mantissa = q[24:2]; guard = q[1]; round and sticky are OR'd together with q[0].
  - RNE: increment when guard && (rest || lsb). A carry out renormalises the mantissa to 1.0 and increments e.
- Range after rounding:
  - e >= 255 -> signed infinity, O=1.
  - e <= 0 -> signed zero, U=1 (no denormal output).
  - else -> {sign, e[7:0], mantissa}.
- DONE: out_valid=1. fp_result and flags are held stable until out_ready; transition to IDLE on the accepting edge. Flags are valid only with out_valid.
- Latency from the accept edge to out_valid:
  - finite nonzero operands: 29 cycles (1 CHECK + 26 DIVIDE + 1 ROUND + DONE entry).
  - special cases: 2 cycles.
- Throughput: the next accept happens no earlier than the cycle after the result handshake.
- Assertions: no X on a/b while in_valid. fp_result stable while out_valid && !out_ready. Exactly one state active.

Decomposition:
- Package float_type gains:
  - enum fp_div_state_t {IDLE, CHECK, DIVIDE, ROUND, DONE}.
  - constants FP_QNAN = 32'h7FC00000, FP_BIAS = 127, FP_INF_EXP = 8'hFF.
  - type_of_float is reused for operand classification.
- Existing if_normal is instantiated twice (one per operand).
- New sub-module div_round_rne: combinational normalise, round and range check. Inputs: q[25:0], sticky, e, sign. Outputs: result word, U, O.

Test Plan:
- 40C00000 / 40000000 (6.0/2.0) -> fp_result 40400000 (3.0), all flags 0; out_valid rises exactly 29 cycles after accept.
- 3F800000 / 40400000 (1/3) -> 3EAAAAAB, exercising the RNE increment. Also 3F800000 / 3F800000 -> 3F800000.
- Special cases, each with out_valid 2 cycles after accept:
  - 3F800000 / 00000000 -> 7F800000, Z=1.
  - BF800000 / 00000000 -> FF800000, Z=1.
  - 00000000 / 00000000 -> 7FC00000, N=1.
  - 7F800000 / 7F800000 -> 7FC00000, N=1.
- Range limits:
  - 7F000000 / 00800000 -> 7F800000, O=1.
  - 00800000 / 40000000 -> 00000000, U=1.
  - 80800000 / 40000000 -> 80000000, U=1.
- Backpressure and throughput: hold out_ready=0 for 10 cycles; fp_result and flags stay stable and in_ready=0. Release out_ready; in_ready=1 the next cycle; a back-to-back second operation gives the correct result.
- Reset mid-operation: assert rst for 1 cycle during DIVIDE (cycle 10). Next cycle: state IDLE, in_ready=1, out_valid=0, outputs 0, no stale result ever emitted. A following 6.0/2.0 returns 40400000.
